muldiv_unit: RTL
================

# muldiv_unit

Iterative 32-bit multiply/divide unit executing the eight RV32M operations, sitting beside the combinational ALU in the execute stage. It takes the same operand pair as the ALU plus a 3-bit funct3 opcode. It stalls the core through `busy` and returns a registered result with a one-cycle `done` pulse. It also provides a `zero_flag` on its result, matching the ALU's output contract so writeback and branch logic can treat both sources uniformly.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- operand_a  in  32  multiplicand / dividend; sampled with start.
- operand_b  in  32  multiplier / divisor; sampled with start.
- md_opcode  in  3  operation code:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  high exactly one cycle; md_result is valid in that cycle.
- md_result  out  32  registered result; holds until the next completion.
- zero_flag  out  1  combinational, (md_result == 0).

## Operation
- States:
  - IDLE → CALC on start, when the operation is not a special case.
  - IDLE → DONE on start, when the operation is a special case.
  - CALC → FIX when the 5-bit iteration counter reaches 31.
  - FIX → DONE.
  - DONE → IDLE.
- Acceptance: at the edge where state = IDLE and start = 1, capture md_opcode and the sign info, then convert operands to magnitudes.
  - Signed sources: MULH both operands, MULHSU operand_a only, DIV/REM both.
  - Unsigned sources: MULHU, DIVU, REMU.
  - Counter is cleared on acceptance.
- Multiply uses shift-add on the 32-bit magnitudes, one multiplier bit per CALC cycle, into a 64-bit accumulator.
  - FIX negates the 64-bit product if the operand signs differ.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide is restoring, one quotient bit per CALC cycle, with a 33-bit partial remainder.
  - FIX negates the quotient if the signs differ (DIV).
  - FIX gives the remainder the sign of the dividend (REM).
- Special cases take the IDLE → DONE path, with md_result loaded at the accepting edge:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → operand_a.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- start is ignored while busy is high, including the DONE cycle. Operand and opcode changes after acceptance have no effect.
- md_result is written only on the FIX → DONE edge or the special-case IDLE → DONE edge.
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE, counter = 0, internal accumulators = 0.
  - md_result = 0, so zero_flag = 1.
  - busy = 0, done = 0.
  - An aborted operation produces no done pulse.

## Timing
- Let edge N be the accepting edge.
- Normal operation:
  - busy rises after edge N.
  - CALC spans edges N+1 … N+32; FIX ends at edge N+33.
  - done = 1 and md_result valid in the cycle after edge N+33.
  - busy and done fall after edge N+34.
- Special case:
  - done = 1 and md_result valid in the cycle after edge N; busy is also high that cycle.
  - busy and done fall after edge N+1.
- Earliest next acceptance: edge N+35 (normal) or N+2 (special), with start held or re-asserted in IDLE.
- Throughput is one operation per 35 cycles; there is no pipelining and no queuing.
- Outputs are registered except zero_flag.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → md_result 0xFFFFFFEB; done exactly in the cycle after edge N+33; busy high for 34 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Special cases, each completing one edge after acceptance:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 0x12345678 / 0 → 0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0 with zero_flag = 1.
- Pulse start with new operands during CALC and during DONE → ignored. The original result is returned, and exactly one done pulse occurs.
- Assert rst_n = 0 at cycle 10 of a DIV → busy, done and md_result go to 0 immediately. After release, a fresh MUL 3 × 4 completes with 12.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_unit_if;
  localparam int unsigned XLEN = 32;

  logic            start;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [2:0]      md_opcode;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] md_result;
  logic            zero_flag;

  modport master (
    output start, operand_a, operand_b, md_opcode,
    input  busy, done, md_result, zero_flag
  );

  modport slave (
    input  start, operand_a, operand_b, md_opcode,
    output busy, done, md_result, zero_flag
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with sign fix-up and single-cycle handling of divide special cases.
module muldiv_unit (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = 5;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            is_div, sgn_a, sgn_b, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, quo, rmd;
  logic [XLEN:0]   mul_sum, rem_shift, rem_trial;
  logic [PW-1:0]   prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    res_d   = res_q;
    acc_d   = acc_q;

    is_div   = bus.md_opcode[2];
    sgn_a    = (bus.md_opcode inside {3'b001, 3'b010, 3'b100, 3'b110}) && bus.operand_a[XLEN-1];
    sgn_b    = (bus.md_opcode inside {3'b001, 3'b100, 3'b110}) && bus.operand_b[XLEN-1];
    a_mag    = sgn_a ? XLEN'(-bus.operand_a) : bus.operand_a;
    b_mag    = sgn_b ? XLEN'(-bus.operand_b) : bus.operand_b;
    div_zero = is_div && (bus.operand_b == '0);
    div_ovf  = is_div && !bus.md_opcode[0] && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
               && (bus.operand_b == '1);

    // Multiplier sits in the low half of acc and is consumed LSB first.
    mul_sum   = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    // Dividend shifts out of a_q MSB first while quotient bits shift in at the bottom.
    rem_shift = {rem_q, a_q[XLEN-1]};
    rem_trial = rem_shift - {1'b0, b_q};

    prod = neg_q ? PW'(-acc_q) : acc_q;
    quo  = neg_q ? XLEN'(-a_q) : a_q;
    rmd  = neg_q ? XLEN'(-rem_q) : rem_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = bus.md_opcode;
          cnt_d = '0;
          a_d   = a_mag;
          b_d   = b_mag;
          rem_d = '0;
          acc_d = {{XLEN{1'b0}}, b_mag};
          neg_d = (bus.md_opcode == 3'b110) ? sgn_a : (sgn_a ^ sgn_b);
          if (div_zero) begin
            res_d   = bus.md_opcode[1] ? bus.operand_a : '1;
            state_d = S_DONE;
          end else if (div_ovf) begin
            res_d   = bus.md_opcode[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = CW'(cnt_q + CW'(1));
        if (op_q[2]) begin
          if (!rem_trial[XLEN]) begin
            rem_d = rem_trial[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        case (op_q)
          3'b000:                 res_d = prod[XLEN-1:0];
          3'b001, 3'b010, 3'b011: res_d = prod[PW-1:XLEN];
          3'b100, 3'b101:         res_d = quo;
          default:                res_d = rmd;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.md_result = res_q;
  assign bus.zero_flag = (res_q == '0);
endmodule
